// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
// Imported by the skid buffer and the reader top.
package fifo_reader_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int STATS_W   = 16;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry output buffer between the FIFO read port and the stream.
// Push writes the tail slot, pop retires the head slot.
module stream_skid_buf2
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  head;
    logic                  tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= 1'b0;
            tail <= 1'b0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            // push and pop together leave the count unchanged
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occ <= 2'd2);
        end
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the synchronous FIFO and presents words as a valid/ready stream.
// Define FIFO_READER_STATS_EN to add the saturating stats_count output.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [STATS_W-1:0]    stats_count
`endif
);

    occ_t                  occ;
    logic                  pending;
    logic                  deq;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [2:0]            occ_after;

    assign deq = m_valid && m_ready;

    // room is judged after this cycle's capture and dequeue settle
    assign occ_after = {1'b0, occ} + {2'b00, pending} - {2'b00, deq};

    assign fifo_rd_en = !rst && en && !fifo_empty && (occ_after < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= fifo_rd_en;
        end
    end

    stream_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (pending),
        .push_data (fifo_rd_data),
        .pop       (deq),
        .occ       (occ),
        .m_valid   (buf_valid),
        .m_data    (buf_data)
    );

    assign m_valid = buf_valid && !rst;
    assign m_data  = rst ? '0 : buf_data;
    assign busy    = !rst && (pending || buf_valid);

`ifdef FIFO_READER_STATS_EN
    logic [STATS_W-1:0] stats_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stats_q <= '0;
        end else if (deq && (stats_q != {STATS_W{1'b1}})) begin
            stats_q <= stats_q + 1'b1;
        end
    end

    assign stats_count = stats_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model.
// Define FIFO_READER_STATS_EN to also exercise stats_count.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       busy;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] stats_count;
`endif

    fifo_stream_reader #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .busy         (busy)
`ifdef FIFO_READER_STATS_EN
        ,
        .stats_count  (stats_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m_ready;
        logic       rd_en;
        logic       valid;
        logic [7:0] data;
        logic       busy;
    } vec_t;

    vec_t       vec [7];
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];
    int         errs  = 0;
    int         chks  = 0;
    int         pops  = 0;
    int         deliv = 0;
    logic       pop_now;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Called just after a negedge once inputs are set.
    task automatic settle();
        logic [7:0] want;
        #2;
        check("rd_en_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
        pop_now = fifo_rd_en && !fifo_empty;
        if (pop_now) pops++;
        if (!rst && m_valid && m_ready) begin
            deliv++;
            if (exp_q.size() == 0) begin
                check("extra_word", {24'd0, m_data}, 32'hFFFF_FFFF);
            end else begin
                want = exp_q.pop_front();
                check("order", {24'd0, m_data}, {24'd0, want});
            end
        end
    endtask

    task automatic adv();
        logic [7:0] w;
        @(posedge clk);
        if (pop_now) begin
            w = fifo_q.pop_front();
            fifo_rd_data <= w;
            fifo_empty   <= (fifo_q.size() == 0);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle();
        adv();
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            settle();
            adv();
            n++;
        end
        check({name, "_timeout"}, {31'd0, n >= limit}, 32'd0);
    endtask

    initial begin
        int base_p;
        int base_d;
        logic pat [6];

        vec[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vec[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        vec[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
        vec[3] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
        vec[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
        vec[5] = '{1'b1, 1'b0, 1'b1, 8'h44, 1'b1};
        vec[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        en = 1'b1;
        m_ready = 1'b1;
        fifo_empty = 1'b1;
        pop_now = 1'b0;
        @(negedge clk);
        load(8'h11);
        load(8'h22);
        adv();

        // reset hold with a non-empty FIFO
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            check("rst_valid", {31'd0, m_valid}, 32'd0);
            check("rst_data", {24'd0, m_data}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            adv();
        end
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        rst = 1'b0;

        // streaming, cycle-by-cycle
        base_d = deliv;
        load(8'h11);
        load(8'h22);
        load(8'h33);
        load(8'h44);
        for (int k = 0; k < 7; k++) begin
            m_ready = vec[k].m_ready;
            settle();
            check($sformatf("stream_rd_en[%0d]", k),
                  {31'd0, fifo_rd_en}, {31'd0, vec[k].rd_en});
            check($sformatf("stream_valid[%0d]", k),
                  {31'd0, m_valid}, {31'd0, vec[k].valid});
            if (vec[k].valid)
                check($sformatf("stream_data[%0d]", k),
                      {24'd0, m_data}, {24'd0, vec[k].data});
            check($sformatf("stream_busy[%0d]", k),
                  {31'd0, busy}, {31'd0, vec[k].busy});
            adv();
        end
        check("stream_count", deliv - base_d, 32'd4);

        // backpressure
        base_p = pops;
        base_d = deliv;
        m_ready = 1'b0;
        load(8'h11);
        load(8'h22);
        load(8'h33);
        load(8'h44);
        for (int k = 0; k < 5; k++) begin
            settle();
            if (k >= 2) check("bp_hold", {24'd0, m_data}, 32'h11);
            adv();
        end
        settle();
        check("bp_pops", pops - base_p, 32'd2);
        check("bp_valid", {31'd0, m_valid}, 32'd1);
        check("bp_data", {24'd0, m_data}, 32'h11);
        check("bp_occ", {30'd0, dut.u_buf.occ}, 32'd2);
        adv();
        m_ready = 1'b1;
        drain("bp_drain", 20);
        check("bp_count", deliv - base_d, 32'd4);
        check("bp_left", exp_q.size(), 32'd0);

        // toggling ready
        base_d = deliv;
        for (int w = 1; w <= 6; w++) load(8'(w));
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0 && !busy) break;
            m_ready = pat[k % 6];
            settle();
            adv();
        end
        check("tog_count", deliv - base_d, 32'd6);
        check("tog_left", exp_q.size(), 32'd0);
        check("tog_busy", {31'd0, busy}, 32'd0);

        // disable right after a pop
        base_p = pops;
        base_d = deliv;
        m_ready = 1'b1;
        en = 1'b1;
        load(8'hA5);
        load(8'hB6);
        settle();
        check("dis_pop", {31'd0, fifo_rd_en}, 32'd1);
        adv();
        en = 1'b0;
        settle();
        check("dis_no_pop", {31'd0, fifo_rd_en}, 32'd0);
        check("dis_busy1", {31'd0, busy}, 32'd1);
        adv();
        settle();
        check("dis_valid", {31'd0, m_valid}, 32'd1);
        check("dis_data", {24'd0, m_data}, 32'hA5);
        adv();
        settle();
        check("dis_busy0", {31'd0, busy}, 32'd0);
        check("dis_valid0", {31'd0, m_valid}, 32'd0);
        adv();
        check("dis_pops", pops - base_p, 32'd1);
        check("dis_deliv", deliv - base_d, 32'd1);
        check("dis_fifo_left", fifo_q.size(), 32'd1);
        do_reset();
        en = 1'b1;

`ifdef FIFO_READER_STATS_EN
        settle();
        check("stats_reset", {16'd0, stats_count}, 32'd0);
        adv();
        for (int w = 0; w < 5; w++) load(8'(8'h60 + w));
        drain("stats_drain", 30);
        check("stats_five", {16'd0, stats_count}, 32'd5);
        force dut.stats_q = 16'hFFFE;
        #1;
        release dut.stats_q;
        for (int w = 0; w < 3; w++) load(8'(8'h70 + w));
        drain("stats_drain2", 30);
        check("stats_sat", {16'd0, stats_count}, 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
